// File: rtl/alu_result_display.sv
// ---------------------------------------------------------------------------
// alu_result_display : sequential double-dabble BCD converter driving three
// 7-segment digits with optional leading-zero blanking.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_result_display #(
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  result,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] C_BLANK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  state_t      r_state;
  state_t      w_next;
  logic        r_have_value;
  logic [7:0]  r_captured;
  logic [19:0] r_sr;
  logic [2:0]  r_count;
  logic [19:0] w_adj;
  logic        w_start;
  logic [3:0]  w_hund;
  logic [3:0]  w_tens;
  logic [3:0]  w_ones;
  logic [6:0]  w_hex0;
  logic [6:0]  w_hex1;
  logic [6:0]  w_hex2;

  // Digits above 9 are unreachable; they fall through to blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? s : ~s;
  endfunction

  assign w_start = !r_have_value || (result != r_captured);

  always_comb begin
    w_adj = r_sr;
    for (int i = 0; i < 3; i++) begin
      if (r_sr[8+4*i +: 4] >= 4'd5)
        w_adj[8+4*i +: 4] = r_sr[8+4*i +: 4] + 4'd3;
    end
  end

  assign w_hund = r_sr[19:16];
  assign w_tens = r_sr[15:12];
  assign w_ones = r_sr[11:8];

  assign w_hex0 = seg_encode(w_ones);
  assign w_hex1 = ((BLANK_LZ != 0) && (w_hund == 4'd0) && (w_tens == 4'd0))
                  ? C_BLANK : seg_encode(w_tens);
  assign w_hex2 = ((BLANK_LZ != 0) && (w_hund == 4'd0))
                  ? C_BLANK : seg_encode(w_hund);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_SHIFT;
      S_SHIFT:  if (r_count == 3'd7) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_have_value <= 1'b0;
      r_captured   <= 8'd0;
      r_sr         <= 20'd0;
      r_count      <= 3'd0;
      bcd          <= 12'd0;
      hex0         <= C_BLANK;
      hex1         <= C_BLANK;
      hex2         <= C_BLANK;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_captured <= result;
            r_sr       <= {12'd0, result};
            r_count    <= 3'd0;
            busy       <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_sr    <= w_adj << 1;
          r_count <= r_count + 3'd1;
        end
        S_COMMIT: begin
          bcd          <= r_sr[19:8];
          hex0         <= w_hex0;
          hex1         <= w_hex1;
          hex2         <= w_hex2;
          done         <= 1'b1;
          busy         <= 1'b0;
          r_have_value <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_display.sv
// ---------------------------------------------------------------------------
// tb_alu_result_display : directed self-checking bench for alu_result_display.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_result_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  result;
  logic [6:0]  hex0, hex1, hex2;
  logic [11:0] bcd;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  alu_result_display #(.BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .result (result),
    .hex0   (hex0),
    .hex1   (hex1),
    .hex2   (hex2),
    .bcd    (bcd),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts edges (including the sampling edge) until done is seen at a negedge.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) return;
      if (busy) bcnt++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  int lat, bcnt, dcnt, bsy, chg;

  initial begin
    rst_n  = 1'b0;
    result = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_hex0", hex0, 7'h7F);
    check("rst_hex1", hex1, 7'h7F);
    check("rst_hex2", hex2, 7'h7F);
    check("rst_bcd",  bcd,  12'h000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // 1: zero after reset release
    rst_n = 1'b1;
    wait_done(lat, bcnt);
    check("t1_lat",  lat,  10);
    check("t1_busy", bcnt, 9);
    check("t1_hex0", hex0, 7'h40);
    check("t1_hex1", hex1, 7'h7F);
    check("t1_hex2", hex2, 7'h7F);
    check("t1_bcd",  bcd,  12'h000);
    check("t1_busy_done", busy, 1'b0);

    // 2: 15
    @(negedge clk);
    result = 8'd15;
    wait_done(lat, bcnt);
    check("t2_lat",  lat,  10);
    check("t2_busy", bcnt, 9);
    check("t2_hex0", hex0, 7'h12);
    check("t2_hex1", hex1, 7'h79);
    check("t2_hex2", hex2, 7'h7F);
    check("t2_bcd",  bcd,  12'h015);
    @(posedge clk);
    @(negedge clk);
    check("t2_done_pulse", done, 1'b0);

    // 3: 255 then 105
    @(negedge clk);
    result = 8'd255;
    wait_done(lat, bcnt);
    check("t3a_hex0", hex0, 7'h12);
    check("t3a_hex1", hex1, 7'h12);
    check("t3a_hex2", hex2, 7'h24);
    check("t3a_bcd",  bcd,  12'h255);
    @(negedge clk);
    result = 8'd105;
    wait_done(lat, bcnt);
    check("t3b_hex0", hex0, 7'h12);
    check("t3b_hex1", hex1, 7'h40);
    check("t3b_hex2", hex2, 7'h79);
    check("t3b_bcd",  bcd,  12'h105);

    // 4: change 15 -> 200 during the third shift
    @(negedge clk);
    result = 8'd15;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    result = 8'd200;
    wait_done(lat, bcnt);
    check("t4a_lat", lat, 7);
    check("t4a_bcd", bcd, 12'h015);
    @(posedge clk);
    @(negedge clk);
    check("t4_rebusy", busy, 1'b1);
    check("t4_done_low", done, 1'b0);
    wait_done(lat, bcnt);
    check("t4b_lat",  lat,  9);
    check("t4b_bcd",  bcd,  12'h200);
    check("t4b_hex0", hex0, 7'h40);
    check("t4b_hex1", hex1, 7'h40);
    check("t4b_hex2", hex2, 7'h24);

    // 5: asynchronous reset mid-shift
    @(negedge clk);
    result = 8'd50;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_hex0", hex0, 7'h7F);
    check("t5_rst_hex2", hex2, 7'h7F);
    check("t5_rst_bcd",  bcd,  12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(lat, bcnt);
    check("t5_lat",  lat,  10);
    check("t5_bcd",  bcd,  12'h050);
    check("t5_hex0", hex0, 7'h40);
    check("t5_hex1", hex1, 7'h12);
    check("t5_hex2", hex2, 7'h7F);

    // 6: steady input, no further conversions
    @(negedge clk);
    result = 8'd80;
    wait_done(lat, bcnt);
    check("t6_bcd", bcd, 12'h080);
    dcnt = 0;
    bsy  = 0;
    chg  = 0;
    repeat (100) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bsy++;
      if (bcd !== 12'h080 || hex0 !== 7'h40 || hex1 !== 7'h00 || hex2 !== 7'h7F) chg++;
    end
    check("t6_done_cnt", dcnt, 0);
    check("t6_busy_cnt", bsy,  0);
    check("t6_changes",  chg,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
